lut_table_loader: RTL and testbench

Runtime writer for LUT-neuron truth tables: accepts a valid/ready stream of table words, writes them into an internal bank of NUM_NEURONS truth tables of 2**IN_BITS one-bit entries, and answers registered lookups against the bank. It is the writing end of the neuron-table interface. Fixed-ROM neurons only read their tables; this block lets a layer be reprogrammed after synthesis, with the same lookup semantics (entry index = neuron input vector, value = 1-bit output).

---
 rtl/lut_pkg.sv | 28 ++
 rtl/lut_table_loader_if.sv | 36 +++
 rtl/lut_bank_ram.sv | 36 +++
 rtl/lut_table_loader.sv | 140 ++++++++++++++
 tb/tb_lut_table_loader.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/lut_pkg.sv
// Shared types and default geometry for the LUT-neuron table loader.
package lut_pkg;

  localparam int DEF_NUM_NEURONS = 64;
  localparam int DEF_IN_BITS     = 8;
  localparam int DEF_WORD_W      = 32;

  localparam int TABLE_DEPTH     = 2 ** DEF_IN_BITS;
  localparam int WORDS_PER_TABLE = TABLE_DEPTH / DEF_WORD_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2,
    ERR  = 2'd3
  } lut_state_t;

  typedef struct packed {
    logic valid;
    logic value;
  } lut_rsp_t;

  // Width helper that never collapses to zero for single-entry ranges.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/lut_table_loader_if.sv
// Load stream plus lookup port of the LUT table loader.
// Handshake: a load word transfers on a rising clk edge where s_valid && s_ready;
// the master holds s_data/s_last/s_par stable while s_valid is high and s_ready low.
interface lut_table_loader_if
  import lut_pkg::*;
#(
  parameter int NUM_NEURONS = DEF_NUM_NEURONS,
  parameter int IN_BITS     = DEF_IN_BITS,
  parameter int WORD_W      = DEF_WORD_W
);
  localparam int NW = idx_w(NUM_NEURONS);

  logic              s_valid;
  logic              s_ready;
  logic [WORD_W-1:0] s_data;
  logic              s_last;
  logic              s_par;
  logic              cfg_done;
  logic              cfg_err;
  logic              q_valid;
  logic [NW-1:0]     q_neuron;
  logic [IN_BITS-1:0] q_addr;
  logic              r_valid;
  logic              r_bit;

  modport master (
    output s_valid, s_data, s_last, s_par, q_valid, q_neuron, q_addr,
    input  s_ready, cfg_done, cfg_err, r_valid, r_bit
  );

  modport slave (
    input  s_valid, s_data, s_last, s_par, q_valid, q_neuron, q_addr,
    output s_ready, cfg_done, cfg_err, r_valid, r_bit
  );

endinterface

// File: rtl/lut_bank_ram.sv
// Bank of one-bit truth tables: word-wide write, one-bit registered read.
// Read and write in the same cycle return the previous contents.
module lut_bank_ram #(
  parameter int NUM_NEURONS = 64,
  parameter int DEPTH       = 256,
  parameter int WORD_W      = 32,
  parameter int NW          = 6,
  parameter int AW          = 8,
  parameter int WW          = 3
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [NW-1:0]     wr_neuron,
  input  logic [WW-1:0]     wr_word,
  input  logic [WORD_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [NW-1:0]     rd_neuron,
  input  logic [AW-1:0]     rd_addr,
  output logic              rd_bit
);

  (* ram_style = "distributed" *) logic [DEPTH-1:0] mem [NUM_NEURONS];

  logic [AW-1:0] wr_base;
  assign wr_base = AW'(wr_word) * AW'(WORD_W);

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_neuron][wr_base +: WORD_W] <= wr_data;
    end
    if (rd_en) begin
      rd_bit <= mem[rd_neuron][rd_addr];
    end
  end

endmodule

// File: rtl/lut_table_loader.sv
// Runtime loader and lookup port for a bank of LUT-neuron truth tables.
// Optional even-parity word check is compiled in with LUT_LOADER_PARITY_EN.
module lut_table_loader
  import lut_pkg::*;
#(
  parameter int NUM_NEURONS = DEF_NUM_NEURONS,
  parameter int IN_BITS     = DEF_IN_BITS,
  parameter int WORD_W      = DEF_WORD_W
) (
  input  logic                clk,
  input  logic                rst,
  lut_table_loader_if.slave   bus,
  output lut_state_t          fsm_state
);

  localparam int DEPTH = 2 ** IN_BITS;
  localparam int WPT   = DEPTH / WORD_W;
  localparam int NW    = idx_w(NUM_NEURONS);
  localparam int WW    = idx_w(WPT);

  localparam logic [WW-1:0] LAST_WORD   = WW'(WPT - 1);
  localparam logic [NW-1:0] LAST_NEURON = NW'(NUM_NEURONS - 1);

  lut_state_t    state;
  logic [WW-1:0] word_idx;
  logic [NW-1:0] neuron_idx;
  logic          s_ready_q;
  logic          cfg_done_q;
  logic          cfg_err_q;
  logic          r_valid_q;
  logic          r_inrange_q;
  logic          ram_bit;
  logic          hs;
  logic          at_final;
  logic          par_ok;
  logic          wr_en;
  logic          q_in_range;
  lut_rsp_t      rsp;

  assign hs       = bus.s_valid && s_ready_q;
  assign at_final = (neuron_idx == LAST_NEURON) && (word_idx == LAST_WORD);

`ifdef LUT_LOADER_PARITY_EN
  assign par_ok = ~(^{bus.s_data, bus.s_par});
`else
  logic unused_par;
  assign unused_par = bus.s_par;
  assign par_ok     = 1'b1;
`endif

  // A word failing parity is dropped rather than written.
  assign wr_en = hs && par_ok;

  generate
    if (NUM_NEURONS == (2 ** NW)) begin : g_full_range
      assign q_in_range = 1'b1;
    end else begin : g_part_range
      assign q_in_range = (32'(bus.q_neuron) < NUM_NEURONS);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      word_idx    <= '0;
      neuron_idx  <= '0;
      s_ready_q   <= 1'b1;
      cfg_done_q  <= 1'b0;
      cfg_err_q   <= 1'b0;
      r_valid_q   <= 1'b0;
      r_inrange_q <= 1'b0;
    end else begin
      r_valid_q   <= bus.q_valid && cfg_done_q;
      r_inrange_q <= q_in_range;
      case (state)
        IDLE, LOAD, DONE: begin
          if (hs) begin
            // s_last must coincide exactly with the final bank position.
            if (!par_ok || (bus.s_last != at_final)) begin
              state      <= ERR;
              s_ready_q  <= 1'b0;
              cfg_done_q <= 1'b0;
              cfg_err_q  <= 1'b1;
            end else if (at_final) begin
              state      <= DONE;
              cfg_done_q <= 1'b1;
              word_idx   <= '0;
              neuron_idx <= '0;
            end else begin
              state      <= LOAD;
              cfg_done_q <= 1'b0;
              if (word_idx == LAST_WORD) begin
                word_idx   <= '0;
                neuron_idx <= neuron_idx + 1'b1;
              end else begin
                word_idx <= word_idx + 1'b1;
              end
            end
          end
        end
        ERR: begin
          state <= ERR;
        end
        default: begin
          state <= ERR;
        end
      endcase
    end
  end

  lut_bank_ram #(
    .NUM_NEURONS (NUM_NEURONS),
    .DEPTH       (DEPTH),
    .WORD_W      (WORD_W),
    .NW          (NW),
    .AW          (IN_BITS),
    .WW          (WW)
  ) u_bank (
    .clk       (clk),
    .wr_en     (wr_en),
    .wr_neuron (neuron_idx),
    .wr_word   (word_idx),
    .wr_data   (bus.s_data),
    .rd_en     (bus.q_valid && cfg_done_q && q_in_range),
    .rd_neuron (bus.q_neuron),
    .rd_addr   (bus.q_addr),
    .rd_bit    (ram_bit)
  );

  assign rsp.valid = r_valid_q;
  assign rsp.value = r_valid_q && r_inrange_q && ram_bit;

  assign bus.s_ready  = s_ready_q;
  assign bus.cfg_done = cfg_done_q;
  assign bus.cfg_err  = cfg_err_q;
  assign bus.r_valid  = rsp.valid;
  assign bus.r_bit    = rsp.value;
  assign fsm_state    = state;

endmodule

// File: tb/tb_lut_table_loader.sv
// Directed bench for lut_table_loader: full loads, framing errors, reset mid-load,
// reload from DONE and (with LUT_LOADER_PARITY_EN) parity rejection.
module tb_lut_table_loader;
  import lut_pkg::*;

  logic       clk;
  logic       rst;
  lut_state_t fsm_state;
  int         total;
  int         bad;

  lut_table_loader_if bus ();

  lut_table_loader dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .fsm_state (fsm_state)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] word_of(input int k, input int w, input bit inv);
    logic [31:0] v;
    v = 32'hA5A5_0000 | (32'(k) << 8) | 32'(w);
    return inv ? ~v : v;
  endfunction

  function automatic logic exp_bit(input int k, input int a, input bit inv);
    logic [31:0] v;
    v = word_of(k, a / 32, inv);
    return v[a % 32];
  endfunction

  task automatic do_reset();
    rst         = 1'b1;
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
    bus.q_valid = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] d, input logic last, input bit par_wrong);
    logic rdy;
    int   n;
    bus.s_data  = d;
    bus.s_last  = last;
    bus.s_par   = (^d) ^ par_wrong;
    bus.s_valid = 1'b1;
    n = 0;
    forever begin
      rdy = bus.s_ready;
      tick();
      if (rdy) break;
      n++;
      if (n > 20) begin
        check("s_ready_timeout", 32'(rdy), 32'd1);
        break;
      end
    end
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
  endtask

  task automatic load(input bit inv, input int first, input int stop_at, input int last_at,
                      input int bad_par, input bit gaps);
    for (int i = first; i <= stop_at; i++) begin
      send_word(word_of(i / 8, i % 8, inv), i == last_at, i == bad_par);
      if (gaps && $urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 2)) tick();
      end
    end
  endtask

  task automatic query(input string tag, input int n, input int a,
                       input logic exp_v, input logic exp_b);
    bus.q_neuron = 6'(n);
    bus.q_addr   = 8'(a);
    bus.q_valid  = 1'b1;
    tick();
    bus.q_valid = 1'b0;
    check({tag, "_rv"}, 32'(bus.r_valid), 32'(exp_v));
    check({tag, "_rb"}, 32'(bus.r_bit), 32'(exp_b));
  endtask

  initial begin
    int qn;
    int qa;
    total        = 0;
    bad          = 0;
    rst          = 1'b1;
    bus.s_valid  = 1'b0;
    bus.s_data   = '0;
    bus.s_last   = 1'b0;
    bus.s_par    = 1'b0;
    bus.q_valid  = 1'b0;
    bus.q_neuron = '0;
    bus.q_addr   = '0;
    tick();
    tick();
    rst = 1'b0;

    check("rst_s_ready", 32'(bus.s_ready), 32'd1);
    check("rst_cfg_done", 32'(bus.cfg_done), 32'd0);
    check("rst_cfg_err", 32'(bus.cfg_err), 32'd0);
    check("rst_state", 32'(fsm_state), 32'(IDLE));
    query("preload", 0, 0, 1'b0, 1'b0);

    // Partial load, lookup mid-load, then reset after word 200.
    load(1'b1, 0, 100, -1, -1, 1'b0);
    check("midload_state", 32'(fsm_state), 32'(LOAD));
    query("midload", 0, 0, 1'b0, 1'b0);
    load(1'b1, 101, 200, -1, -1, 1'b0);
    do_reset();
    check("midrst_state", 32'(fsm_state), 32'(IDLE));
    check("midrst_done", 32'(bus.cfg_done), 32'd0);
    check("midrst_err", 32'(bus.cfg_err), 32'd0);
    check("midrst_ready", 32'(bus.s_ready), 32'd1);

    // Full load with random s_valid gaps.
    load(1'b0, 0, 510, 511, -1, 1'b1);
    check("done_before_last", 32'(bus.cfg_done), 32'd0);
    load(1'b0, 511, 511, 511, -1, 1'b0);
    check("done_after_last", 32'(bus.cfg_done), 32'd1);
    check("done_state", 32'(fsm_state), 32'(DONE));
    query("n3_a02", 3, 8'h02, 1'b1, 1'b0);
    query("n3_a00", 3, 8'h00, 1'b1, 1'b0);
    query("n3_a08", 3, 8'h08, 1'b1, 1'b1);
    query("n3_a16", 3, 16, 1'b1, 1'b1);
    query("n5_a09", 5, 9, 1'b1, 1'b0);
    query("n5_a10", 5, 10, 1'b1, 1'b1);
    query("n63_a237", 63, 237, 1'b1, 1'b1);
    query("n63_a238", 63, 238, 1'b1, 1'b0);
    query("n63_a224", 63, 224, 1'b1, 1'b1);
    query("n63_a227", 63, 227, 1'b1, 1'b0);

    // Back-to-back lookups, each answered the following cycle.
    bus.q_valid = 1'b1;
    for (int j = 0; j < 16; j++) begin
      qn = $urandom_range(0, 63);
      qa = $urandom_range(0, 255);
      bus.q_neuron = 6'(qn);
      bus.q_addr   = 8'(qa);
      tick();
      check("b2b_rv", 32'(bus.r_valid), 32'd1);
      check("b2b_rb", 32'(bus.r_bit), 32'(exp_bit(qn, qa, 1'b0)));
    end
    bus.q_valid = 1'b0;
    tick();
    check("idle_rv", 32'(bus.r_valid), 32'd0);

    // Reload from DONE: same-cycle lookup sees old contents, cfg_done then drops.
    bus.q_neuron = 6'd0;
    bus.q_addr   = 8'd16;
    bus.q_valid  = 1'b1;
    send_word(word_of(0, 0, 1'b1), 1'b0, 1'b0);
    bus.q_valid = 1'b0;
    check("reload_old_rv", 32'(bus.r_valid), 32'd1);
    check("reload_old_rb", 32'(bus.r_bit), 32'd1);
    check("reload_done_drop", 32'(bus.cfg_done), 32'd0);
    check("reload_state", 32'(fsm_state), 32'(LOAD));
    query("reload_q", 0, 0, 1'b0, 1'b0);
    load(1'b1, 1, 511, 511, -1, 1'b1);
    check("reload_done", 32'(bus.cfg_done), 32'd1);
    query("inv_n0_a16", 0, 16, 1'b1, 1'b0);
    query("inv_n3_a08", 3, 8, 1'b1, 1'b0);
    query("inv_n3_a02", 3, 2, 1'b1, 1'b1);
    query("inv_n63_a238", 63, 238, 1'b1, 1'b1);

    // s_last too early.
    do_reset();
    load(1'b0, 0, 100, 100, -1, 1'b0);
    check("early_err", 32'(bus.cfg_err), 32'd1);
    check("early_ready", 32'(bus.s_ready), 32'd0);
    check("early_done", 32'(bus.cfg_done), 32'd0);
    check("early_state", 32'(fsm_state), 32'(ERR));
    query("early_q", 0, 0, 1'b0, 1'b0);

    // Final word without s_last.
    do_reset();
    load(1'b0, 0, 511, -1, -1, 1'b0);
    check("nolast_err", 32'(bus.cfg_err), 32'd1);
    check("nolast_done", 32'(bus.cfg_done), 32'd0);

    // Word 7 carries a wrong parity bit.
    do_reset();
`ifdef LUT_LOADER_PARITY_EN
    load(1'b0, 0, 7, 511, 7, 1'b0);
    check("par_err", 32'(bus.cfg_err), 32'd1);
    check("par_done", 32'(bus.cfg_done), 32'd0);
    check("par_ready", 32'(bus.s_ready), 32'd0);
`else
    load(1'b0, 0, 511, 511, 7, 1'b0);
    check("par_ignored_done", 32'(bus.cfg_done), 32'd1);
    check("par_ignored_err", 32'(bus.cfg_err), 32'd0);
    query("par_n0_a224", 0, 224, 1'b1, 1'b1);
    query("par_n0_a226", 0, 226, 1'b1, 1'b1);
    query("par_n0_a227", 0, 227, 1'b1, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
